// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access widths, MemToReg selects,
// and the alignment rule used by the decoder, EX/MEM register and MEM stage.
// No logic, no state.
package mem_stage_pkg;

  // Access width as produced by the decoder; the reserved code behaves as word.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } access_size_t;

  // Write-back source select carried alongside the instruction.
  localparam logic [2:0] MTR_ALU = 3'd0;
  localparam logic [2:0] MTR_MEM = 3'd1;
  localparam logic [2:0] MTR_PC4 = 3'd2;

  localparam int MEM_WORDS  = 1024;
  localparam int MEM_AW     = 10;

  // Halfwords need an even address; words (and reserved) need a 4-byte boundary.
  function automatic logic is_misaligned(input access_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Data memory: 1024 x 32-bit array with a byte-lane write port and async read.
// Latency: write commits on the rising edge; read is combinational.
// Ports: clk, i_we, i_addr (word index), i_be (lane enables), i_wdata, o_rdata.
module data_memory
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  // Contents start at zero and are deliberately untouched by the stage reset.
  logic [31:0] r_mem [0:MEM_WORDS-1] = '{default: '0};

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: alignment check, store lane steering, load extraction
// and extension, MEM/WB output registers. Latency: 1 cycle inputs -> outputs.
// Stall holds all outputs and blocks stores; Flush/Reset register zeros.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic [2:0]  MemToReg_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] WriteMemData_in,
  input  logic [4:0]  WriteReg_in,
  input  logic [31:0] pcresultPlus4_in,
  input  logic [1:0]  AccessSize,
  input  logic        LoadUnsigned,
  input  logic        Stall,
  input  logic        Flush,
  output logic        RegWrite_out,
  output logic [2:0]  MemToReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  WriteReg_out,
  output logic [31:0] pcresultPlus4_out,
  output logic        MisalignFault
);

  access_size_t w_size;
  logic [1:0]   w_lane;
  logic         w_misalign;
  logic         w_fault;
  logic         w_we;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata;
  logic [31:0]  w_rdata;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [31:0]  w_load;

  assign w_size     = access_size_t'(AccessSize);
  assign w_lane     = ALUResult_in[1:0];
  assign w_misalign = is_misaligned(w_size, w_lane);
  assign w_fault    = w_misalign & (MemRead_in | MemWrite_in);
  assign w_we       = MemWrite_in & ~w_misalign & ~Stall & ~Flush & ~Reset;

  // Sub-word store data is replicated across lanes; the byte enables pick the lane.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteMemData_in;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteMemData_in[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteMemData_in[15:0]}};
      end
      default: ;
    endcase
  end

  data_memory u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (ALUResult_in[11:2]),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_byte = w_rdata[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_load = w_rdata;
    case (w_size)
      SZ_BYTE: w_load = LoadUnsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load = LoadUnsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset || Flush) begin
      RegWrite_out      <= 1'b0;
      MemToReg_out      <= '0;
      ReadData_out      <= '0;
      ALUResult_out     <= '0;
      WriteReg_out      <= '0;
      pcresultPlus4_out <= '0;
      MisalignFault     <= 1'b0;
    end else if (!Stall) begin
      RegWrite_out      <= RegWrite_in & ~w_fault;
      MemToReg_out      <= MemToReg_in;
      // A faulting load returns zero rather than a partially valid word.
      ReadData_out      <= (MemRead_in && !w_fault) ? w_load : 32'd0;
      ALUResult_out     <= ALUResult_in;
      WriteReg_out      <= WriteReg_in;
      pcresultPlus4_out <= pcresultPlus4_in;
      MisalignFault     <= w_fault;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        Reset;
  logic        RegWrite_in, MemWrite_in, MemRead_in;
  logic [2:0]  MemToReg_in;
  logic [31:0] ALUResult_in, WriteMemData_in, pcresultPlus4_in;
  logic [4:0]  WriteReg_in;
  logic [1:0]  AccessSize;
  logic        LoadUnsigned, Stall, Flush;
  logic        RegWrite_out;
  logic [2:0]  MemToReg_out;
  logic [31:0] ReadData_out, ALUResult_out, pcresultPlus4_out;
  logic [4:0]  WriteReg_out;
  logic        MisalignFault;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .Reset             (Reset),
    .RegWrite_in       (RegWrite_in),
    .MemWrite_in       (MemWrite_in),
    .MemRead_in        (MemRead_in),
    .MemToReg_in       (MemToReg_in),
    .ALUResult_in      (ALUResult_in),
    .WriteMemData_in   (WriteMemData_in),
    .WriteReg_in       (WriteReg_in),
    .pcresultPlus4_in  (pcresultPlus4_in),
    .AccessSize        (AccessSize),
    .LoadUnsigned      (LoadUnsigned),
    .Stall             (Stall),
    .Flush             (Flush),
    .RegWrite_out      (RegWrite_out),
    .MemToReg_out      (MemToReg_out),
    .ReadData_out      (ReadData_out),
    .ALUResult_out     (ALUResult_out),
    .WriteReg_out      (WriteReg_out),
    .pcresultPlus4_out (pcresultPlus4_out),
    .MisalignFault     (MisalignFault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rw, input logic mw, input logic mr, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [4:0] wr, input logic [2:0] mtr, input logic [31:0] pc);
    RegWrite_in      = rw;
    MemWrite_in      = mw;
    MemRead_in       = mr;
    AccessSize       = sz;
    LoadUnsigned     = uns;
    ALUResult_in     = addr;
    WriteMemData_in  = wd;
    WriteReg_in      = wr;
    MemToReg_in      = mtr;
    pcresultPlus4_in = pc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rw"},  {31'd0, RegWrite_out},  32'd0);
    chk({tag, ".mtr"}, {29'd0, MemToReg_out},  32'd0);
    chk({tag, ".rd"},  ReadData_out,           32'd0);
    chk({tag, ".alu"}, ALUResult_out,          32'd0);
    chk({tag, ".wr"},  {27'd0, WriteReg_out},  32'd0);
    chk({tag, ".pc"},  pcresultPlus4_out,      32'd0);
    chk({tag, ".flt"}, {31'd0, MisalignFault}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    op(1, 0, 1, 2'b00, 0, 32'h0000_0104, 32'hFFFF_FFFF, 5'd9, MTR_MEM, 32'h0000_0050);
    tick(); tick();
    chk_all_zero("reset");
    Reset = 1'b0;

    // sb 0xF5 -> 0x103, then lb / lbu / lw around it
    op(0, 1, 0, 2'b10, 0, 32'h0000_0103, 32'h0000_00F5, 5'd0, MTR_ALU, 32'h0000_0040);
    tick();
    chk("sb.rw", {31'd0, RegWrite_out}, 32'd0);
    op(1, 0, 1, 2'b10, 0, 32'h0000_0103, 32'h0, 5'd5, MTR_MEM, 32'h0000_0044);
    tick();
    chk("lb.rd",  ReadData_out,                32'hFFFF_FFF5);
    chk("lb.alu", ALUResult_out,               32'h0000_0103);
    chk("lb.wr",  {27'd0, WriteReg_out},       32'd5);
    chk("lb.mtr", {29'd0, MemToReg_out},       32'd1);
    chk("lb.pc",  pcresultPlus4_out,           32'h0000_0044);
    chk("lb.rw",  {31'd0, RegWrite_out},       32'd1);
    op(1, 0, 1, 2'b10, 1, 32'h0000_0103, 32'h0, 5'd6, MTR_MEM, 32'h0000_0048);
    tick();
    chk("lbu.rd", ReadData_out, 32'h0000_00F5);
    op(1, 0, 1, 2'b00, 0, 32'h0000_0100, 32'h0, 5'd7, MTR_MEM, 32'h0000_004C);
    tick();
    chk("lw100.rd", ReadData_out, 32'hF500_0000);

    // sw 0x8001ABCD -> 0x200; non-read must zero ReadData
    op(0, 1, 0, 2'b00, 0, 32'h0000_0200, 32'h8001_ABCD, 5'd0, MTR_PC4, 32'h0000_0050);
    tick();
    chk("sw200.rd0", ReadData_out, 32'd0);
    chk("sw200.mtr", {29'd0, MemToReg_out}, 32'd2);
    op(1, 0, 1, 2'b01, 1, 32'h0000_0202, 32'h0, 5'd8, MTR_MEM, 32'h0);
    tick();
    chk("lhu202", ReadData_out, 32'h0000_8001);
    op(1, 0, 1, 2'b01, 0, 32'h0000_0202, 32'h0, 5'd8, MTR_MEM, 32'h0);
    tick();
    chk("lh202", ReadData_out, 32'hFFFF_8001);
    op(1, 0, 1, 2'b01, 0, 32'h0000_0200, 32'h0, 5'd8, MTR_MEM, 32'h0);
    tick();
    chk("lh200", ReadData_out, 32'hFFFF_ABCD);
    op(1, 0, 1, 2'b10, 1, 32'h0000_0201, 32'h0, 5'd8, MTR_MEM, 32'h0);
    tick();
    chk("lbu201", ReadData_out, 32'h0000_00AB);

    // misaligned sw to 0x6
    op(1, 1, 0, 2'b00, 0, 32'h0000_0006, 32'h1234_5678, 5'd3, MTR_ALU, 32'h0);
    tick();
    chk("mis.flt", {31'd0, MisalignFault}, 32'd1);
    chk("mis.rw",  {31'd0, RegWrite_out},  32'd0);
    op(1, 0, 1, 2'b00, 0, 32'h0000_0004, 32'h0, 5'd3, MTR_MEM, 32'h0);
    tick();
    chk("mis.flt1", {31'd0, MisalignFault}, 32'd0);
    chk("mis.rw1",  {31'd0, RegWrite_out},  32'd1);
    chk("mis.mem4", ReadData_out,           32'd0);
    op(1, 0, 1, 2'b01, 0, 32'h0000_0201, 32'h0, 5'd3, MTR_MEM, 32'h0);
    tick();
    chk("mislh.flt", {31'd0, MisalignFault}, 32'd1);

    // stall then flush+stall: no commit, outputs held then zeroed
    op(1, 0, 1, 2'b00, 0, 32'h0000_0200, 32'h0, 5'd4, MTR_MEM, 32'h0000_0060);
    tick();
    chk("pre.rd", ReadData_out, 32'h8001_ABCD);
    op(0, 1, 0, 2'b00, 0, 32'h0000_0300, 32'h55AA_55AA, 5'd7, MTR_ALU, 32'h0000_0064);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.alu", ALUResult_out, 32'h0000_0200);
      chk("stall.rd",  ReadData_out,  32'h8001_ABCD);
      chk("stall.pc",  pcresultPlus4_out, 32'h0000_0060);
    end
    Flush = 1'b1;
    tick();
    chk_all_zero("flush");
    Flush = 1'b0; Stall = 1'b0;
    op(1, 0, 1, 2'b00, 0, 32'h0000_0300, 32'h0, 5'd4, MTR_MEM, 32'h0);
    tick();
    chk("nocommit.rd", ReadData_out, 32'd0);

    // stall 3 cycles then release: store commits on the first free edge
    op(0, 1, 0, 2'b00, 0, 32'h0000_0300, 32'h55AA_55AA, 5'd7, MTR_ALU, 32'h0000_0070);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall2.pc", pcresultPlus4_out, 32'd0);
    end
    Stall = 1'b0;
    tick();
    chk("release.pc", pcresultPlus4_out, 32'h0000_0070);
    op(1, 0, 1, 2'b00, 0, 32'h0000_0300, 32'h0, 5'd4, MTR_MEM, 32'h0);
    tick();
    chk("commit.rd", ReadData_out, 32'h55AA_55AA);

    // address wrap and reset retention
    op(0, 1, 0, 2'b00, 0, 32'h0000_1010, 32'hDEAD_BEEF, 5'd0, MTR_ALU, 32'h0);
    tick();
    op(1, 0, 1, 2'b00, 0, 32'h0000_0010, 32'h0, 5'd2, MTR_MEM, 32'h0000_0080);
    tick();
    chk("wrap.rd", ReadData_out, 32'hDEAD_BEEF);
    op(1, 1, 0, 2'b00, 0, 32'h0000_0010, 32'h1111_1111, 5'd2, MTR_MEM, 32'h0000_0084);
    Reset = 1'b1;
    tick();
    chk_all_zero("rst2");
    Reset = 1'b0;
    op(1, 0, 1, 2'b00, 0, 32'h0000_0010, 32'h0, 5'd2, MTR_MEM, 32'h0000_0088);
    tick();
    chk("rst2.rd", ReadData_out,      32'hDEAD_BEEF);
    chk("rst2.pc", pcresultPlus4_out, 32'h0000_0088);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock `clk` and one synchronous, active-high reset `Reset`. There is no other clock or reset.
REQ-002 Port `clk`, input, 1: rising-edge clock for all state.
REQ-003 Port `Reset`, input, 1: synchronous, active-high reset.
REQ-004 Inputs from the EX/MEM register:
- `RegWrite_in` (1)
- `MemWrite_in` (1)
- `MemRead_in` (1)
- `MemToReg_in` (3)
- `ALUResult_in` (32): byte address, or result passed through
- `WriteMemData_in` (32)
- `WriteReg_in` (5)
- `pcresultPlus4_in` (32)
REQ-005 Input `AccessSize` (2) SHALL encode the access width: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
REQ-006 Input `LoadUnsigned` (1): 1 selects zero-extension of sub-word loads; 0 selects sign-extension.
REQ-007 Input `Stall` (1) holds the stage. Input `Flush` (1) inserts a bubble.
REQ-008 Outputs to WB, all registered:
- `RegWrite_out` (1)
- `MemToReg_out` (3)
- `ReadData_out` (32)
- `ALUResult_out` (32)
- `WriteReg_out` (5)
- `pcresultPlus4_out` (32)
- `MisalignFault` (1)

Function
REQ-009 The data memory SHALL be 1024 x 32-bit words, indexed by `ALUResult_in[11:2]`. Address bits [31:12] are ignored, so addresses wrap every 4 KB.
REQ-010 Stores SHALL commit on the rising edge where all of the following hold: `MemWrite_in`=1, `Stall`=0, `Flush`=0, `Reset`=0, access aligned.
REQ-011 Byte stores SHALL write only the lane selected by address[1:0]. Halfword stores write the lane selected by address[1]. Other bytes are unchanged. Lane 0 = bits [7:0].
REQ-012 The load path SHALL combinationally read the addressed word, extract the lane, and extend it per `LoadUnsigned`. The result is registered into `ReadData_out`, giving 1-cycle latency from EX/MEM inputs to WB outputs.
REQ-013 A load issued the cycle after a store to the same word SHALL return the newly stored data.
REQ-014 When `MemRead_in`=0, `ReadData_out` SHALL register 0.
REQ-015 An access is misaligned when either holds:
- halfword with address[0]=1
- word/reserved with address[1:0]≠00
REQ-016 On a misaligned access with `MemRead_in` or `MemWrite_in` set:
- the store is suppressed
- `RegWrite_out` registers 0
- `MisalignFault` registers 1 for exactly one cycle
REQ-017 When `Stall`=1 (and no `Flush`/`Reset`), all outputs SHALL hold their values and no store commits.
REQ-018 When `Flush`=1, all outputs SHALL register 0 and no store commits.
REQ-019 Priority SHALL be `Reset` > `Flush` > `Stall` > normal operation.
REQ-020 The non-memory fields (`ALUResult`, `WriteReg`, `MemToReg`, `pcresultPlus4`) SHALL pass through unmodified with 1-cycle latency.

Reset
REQ-021 While `Reset`=1 at a rising edge, every output SHALL register 0 and no store commits.
REQ-022 Memory contents SHALL be zero at time 0 and SHALL NOT be cleared by `Reset`.
REQ-023 A `Reset` asserted mid-operation SHALL discard the in-flight access. The first edge after `Reset` deasserts processes the inputs then present.

Structure
REQ-024 The `AccessSize` codes and `MemToReg` encodings SHALL live in a shared package used by the decoder, EX/MEM register and this stage.
REQ-025 Storage SHALL be a sub-module `data_memory`, containing the array plus the byte-lane write port. `mem_stage` holds the alignment check, extension logic and MEM/WB registers.

Verification
REQ-026 Byte store, then signed load: sb 0x000000F5 to 0x103, then lb at 0x103 → `ReadData_out`=0xFFFFFFF5. Word 0x100 holds 0xF5000000.
REQ-027 Halfword unsigned load: store word 0x8001ABCD at 0x200, then lhu at 0x202 → `ReadData_out`=0x00008001. The same access with `LoadUnsigned`=0 → 0xFFFF8001.
REQ-028 Misalignment: sw to 0x0006 with data 0x12345678 → `MisalignFault`=1 for one cycle, `RegWrite_out`=0, and word 0x0004 is unchanged.
REQ-029 Stall and flush:
- `Stall`=1 for 3 cycles during a sw → outputs frozen, memory unchanged; the store commits on the first unstalled edge.
- `Flush` and `Stall` asserted together → all outputs 0.
REQ-030 Wrap and reset:
- sw 0xDEADBEEF to 0x00001010, then lw at 0x010 → 0xDEADBEEF.
- Assert `Reset` for 1 cycle → outputs 0; a following lw at 0x010 still returns 0xDEADBEEF.
